// File: rtl/mem_access.sv
// Memory-stage load/store unit: drives the SRAM-like data bus for the M-stage
// instruction, formats store data and load results, and raises address errors.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  l_s_typeM,
  input  logic [31:0] alu_outM,
  input  logic [31:0] rt_valueM,
  input  logic        exc_flushM,
  input  logic        stall_ext,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        adelM,
  output logic        adesM,
  output logic [31:0] badvaddrM,
  output logic [31:0] mem_rdataM,
  output logic        mem_stall
);

  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE} state_e;

  state_e      state_q;
  logic [31:0] result_q;
  logic        discard_q;

  logic        isLoad;
  logic        isStore;
  logic        isHalf;
  logic        isWord;
  logic        addrErr;
  logic        go;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadExt;

  assign isLoad  = |l_s_typeM[4:0];
  assign isStore = |l_s_typeM[7:5];
  assign isHalf  = l_s_typeM[2] | l_s_typeM[3] | l_s_typeM[6];
  assign isWord  = l_s_typeM[4] | l_s_typeM[7];
  assign addrErr = (isHalf & alu_outM[0]) | (isWord & (alu_outM[1:0] != 2'b00));

  assign adelM     = isLoad & addrErr;
  assign adesM     = isStore & addrErr;
  assign badvaddrM = alu_outM;
  assign go        = (l_s_typeM != 8'd0) & ~adelM & ~adesM & ~exc_flushM;

  assign data_wr   = isStore;
  assign data_size = isWord ? 2'd2 : (isHalf ? 2'd1 : 2'd0);
  assign data_addr = alu_outM;

  always_comb begin
    data_wdata = rt_valueM;
    if (l_s_typeM[5])
      data_wdata = {4{rt_valueM[7:0]}};
    else if (l_s_typeM[6])
      data_wdata = {2{rt_valueM[15:0]}};
  end

  always_comb begin
    case (alu_outM[1:0])
      2'd0:    byteSel = data_rdata[7:0];
      2'd1:    byteSel = data_rdata[15:8];
      2'd2:    byteSel = data_rdata[23:16];
      default: byteSel = data_rdata[31:24];
    endcase
    halfSel = alu_outM[1] ? data_rdata[31:16] : data_rdata[15:0];
    loadExt = data_rdata;
    if (l_s_typeM[0])
      loadExt = {{24{byteSel[7]}}, byteSel};
    else if (l_s_typeM[1])
      loadExt = {24'd0, byteSel};
    else if (l_s_typeM[2])
      loadExt = {{16{halfSel[15]}}, halfSel};
    else if (l_s_typeM[3])
      loadExt = {16'd0, halfSel};
  end

  // An accepted transaction always runs to data_ok; a flush only discards its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      result_q  <= 32'd0;
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          discard_q <= 1'b0;
          if (go)
            state_q <= data_addr_ok ? WAIT_DATA : WAIT_ADDR;
        end
        WAIT_ADDR: begin
          if (data_addr_ok) begin
            state_q   <= WAIT_DATA;
            discard_q <= exc_flushM;
          end else if (exc_flushM) begin
            state_q <= IDLE;
          end
        end
        WAIT_DATA: begin
          if (data_data_ok) begin
            discard_q <= 1'b0;
            if (discard_q | exc_flushM) begin
              state_q <= IDLE;
            end else begin
              result_q <= loadExt;
              state_q  <= stall_ext ? DONE : IDLE;
            end
          end else if (exc_flushM) begin
            discard_q <= 1'b1;
          end
        end
        DONE: begin
          if (!stall_ext)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_req   = ((state_q == IDLE) & go) | (state_q == WAIT_ADDR);
  assign mem_stall  = data_req | ((state_q == WAIT_DATA) & ~data_data_ok);
  assign mem_rdataM = ((state_q == WAIT_DATA) & data_data_ok) ? loadExt : result_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed accesses push expected bus requests
// and load results; monitors compare them whenever the DUT presents them.
module tb_mem_access;

  localparam logic [7:0] LB = 8'h01, LBU = 8'h02, LH = 8'h04, LHU = 8'h08, LW = 8'h10;
  localparam logic [7:0] SB = 8'h20, SH = 8'h40, SW = 8'h80;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } reqExp_t;

  typedef struct packed {
    logic        chk;
    logic [31:0] val;
  } resExp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  l_s_typeM;
  logic [31:0] alu_outM;
  logic [31:0] rt_valueM;
  logic        exc_flushM;
  logic        stall_ext;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        adelM;
  logic        adesM;
  logic [31:0] badvaddrM;
  logic [31:0] mem_rdataM;
  logic        mem_stall;

  int testsRun = 0;
  int testsFailed = 0;

  reqExp_t reqQ[$];
  resExp_t resQ[$];

  mem_access dut (
    .clk(clk), .rst(rst),
    .l_s_typeM(l_s_typeM), .alu_outM(alu_outM), .rt_valueM(rt_valueM),
    .exc_flushM(exc_flushM), .stall_ext(stall_ext),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .adelM(adelM), .adesM(adesM), .badvaddrM(badvaddrM),
    .mem_rdataM(mem_rdataM), .mem_stall(mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] typ, input logic [31:0] addr, input logic [31:0] rt,
                               input logic flush, input logic stallExt, input logic addrOk,
                               input logic dataOk, input logic [31:0] rdata);
    l_s_typeM    = typ;
    alu_outM     = addr;
    rt_valueM    = rt;
    exc_flushM   = flush;
    stall_ext    = stallExt;
    data_addr_ok = addrOk;
    data_data_ok = dataOk;
    data_rdata   = rdata;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Request monitor: every asserted request must match the head of reqQ; acceptance pops it.
  always @(negedge clk) begin
    if (data_req) begin
      if (reqQ.size() == 0) begin
        checkOutput("req_unexpected", 32'(data_req), 32'd0);
      end else begin
        checkOutput("req_wr", 32'(data_wr), 32'(reqQ[0].wr));
        checkOutput("req_size", 32'(data_size), 32'(reqQ[0].size));
        checkOutput("req_addr", data_addr, reqQ[0].addr);
        checkOutput("req_wdata", data_wdata, reqQ[0].wdata);
        if (data_addr_ok)
          void'(reqQ.pop_front());
      end
    end
  end

  // Response monitor: each data_ok retires one expected result.
  always @(negedge clk) begin : rspMonitor
    resExp_t rsp;
    if (data_data_ok) begin
      if (resQ.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(data_data_ok), 32'd0);
      end else begin
        rsp = resQ.pop_front();
        if (rsp.chk)
          checkOutput("load_result", mem_rdataM, rsp.val);
      end
    end
  end

  initial begin
    logic [7:0]  errTyp  [5] = '{LW, SW, LH, SH, LHU};
    logic [31:0] errAddr [5] = '{32'h6, 32'h2, 32'h3, 32'h1, 32'h1};
    logic        errAdel [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    applyStimulus(8'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req", 32'(data_req), 32'd0);
    checkOutput("rst_stall", 32'(mem_stall), 32'd0);
    checkOutput("rst_rdata", mem_rdataM, 32'd0);
    nextCycle;
    rst = 1'b0;

    // LB at 0x1003, minimum latency
    reqQ.push_back('{1'b0, 2'd0, 32'h1003, 32'h0});
    resQ.push_back('{1'b1, 32'hFFFFFF80});
    applyStimulus(LB, 32'h1003, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("lb_stall_req", 32'(mem_stall), 32'd1);
    nextCycle;
    applyStimulus(LB, 32'h1003, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80FF7F01);
    @(negedge clk);
    checkOutput("lb_stall_data", 32'(mem_stall), 32'd0);
    checkOutput("lb_req_low", 32'(data_req), 32'd0);
    nextCycle;

    // SH with addr_ok delayed three cycles
    reqQ.push_back('{1'b1, 2'd1, 32'h2002, 32'hABCDABCD});
    resQ.push_back('{1'b0, 32'h0});
    for (int i = 0; i < 4; i++) begin
      applyStimulus(SH, 32'h2002, 32'h1234ABCD, 1'b0, 1'b0, (i == 3), 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("sh_req_held", 32'(data_req), 32'd1);
      checkOutput("sh_stall_held", 32'(mem_stall), 32'd1);
      nextCycle;
    end
    applyStimulus(SH, 32'h2002, 32'h1234ABCD, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    @(negedge clk);
    checkOutput("sh_stall_done", 32'(mem_stall), 32'd0);
    nextCycle;

    // SB replicates the low byte
    reqQ.push_back('{1'b1, 2'd0, 32'h3001, 32'hA5A5A5A5});
    resQ.push_back('{1'b0, 32'h0});
    applyStimulus(SB, 32'h3001, 32'h123456A5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    nextCycle;
    applyStimulus(SB, 32'h3001, 32'h123456A5, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    nextCycle;

    // Misaligned accesses and a flushed access never reach the bus
    for (int i = 0; i < 5; i++) begin
      applyStimulus(errTyp[i], errAddr[i], 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      @(negedge clk);
      checkOutput("err_adel", 32'(adelM), 32'(errAdel[i]));
      checkOutput("err_ades", 32'(adesM), 32'(!errAdel[i]));
      checkOutput("err_badvaddr", badvaddrM, errAddr[i]);
      checkOutput("err_req", 32'(data_req), 32'd0);
      checkOutput("err_stall", 32'(mem_stall), 32'd0);
      nextCycle;
    end
    applyStimulus(LB, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("flush_idle_req", 32'(data_req), 32'd0);
    checkOutput("flush_idle_stall", 32'(mem_stall), 32'd0);
    nextCycle;

    // LHU held through DONE while stall_ext is high, then back-to-back LW
    reqQ.push_back('{1'b0, 2'd1, 32'h2, 32'h0});
    resQ.push_back('{1'b1, 32'h0000BEEF});
    applyStimulus(LHU, 32'h2, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    nextCycle;
    applyStimulus(LHU, 32'h2, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hBEEF0000);
    @(negedge clk);
    checkOutput("lhu_stall_data", 32'(mem_stall), 32'd0);
    nextCycle;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(LHU, 32'h2, 32'h0, 1'b0, (i < 2), 1'b0, 1'b0, 32'h12345678);
      @(negedge clk);
      checkOutput("done_rdata", mem_rdataM, 32'h0000BEEF);
      checkOutput("done_stall", 32'(mem_stall), 32'd0);
      checkOutput("done_req", 32'(data_req), 32'd0);
      nextCycle;
    end
    reqQ.push_back('{1'b0, 2'd2, 32'h100, 32'h0});
    resQ.push_back('{1'b1, 32'hCAFEF00D});
    applyStimulus(LW, 32'h100, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("b2b_req", 32'(data_req), 32'd1);
    nextCycle;
    applyStimulus(LW, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
    nextCycle;

    // LW flushed while waiting for data: the late data is discarded
    reqQ.push_back('{1'b0, 2'd2, 32'h200, 32'h0});
    resQ.push_back('{1'b0, 32'h0});
    applyStimulus(LW, 32'h200, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    nextCycle;
    applyStimulus(LW, 32'h200, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("flush_wait_stall", 32'(mem_stall), 32'd1);
    nextCycle;
    applyStimulus(LW, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("flush_wait_stall2", 32'(mem_stall), 32'd1);
    nextCycle;
    applyStimulus(LW, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    nextCycle;
    applyStimulus(8'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("flush_result_kept", mem_rdataM, 32'hCAFEF00D);
    checkOutput("flush_no_req", 32'(data_req), 32'd0);
    checkOutput("flush_stall", 32'(mem_stall), 32'd0);
    nextCycle;

    // Reset while a store waits for addr_ok
    reqQ.push_back('{1'b1, 2'd2, 32'h300, 32'h11223344});
    applyStimulus(SW, 32'h300, 32'h11223344, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    nextCycle;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_wait_req", 32'(data_req), 32'd1);
    nextCycle;
    rst = 1'b0;
    reqQ.delete();
    applyStimulus(8'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("rst_mid_req", 32'(data_req), 32'd0);
    checkOutput("rst_mid_stall", 32'(mem_stall), 32'd0);
    checkOutput("rst_mid_rdata", mem_rdataM, 32'd0);
    nextCycle;

    checkOutput("reqq_drained", 32'(reqQ.size()), 32'd0);
    checkOutput("resq_drained", 32'(resQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage load/store unit of the 5-stage MIPS pipeline, sitting directly downstream of the EX/MEM pipeline register. It turns the registered M-stage address, store data and load/store type into a transaction on the SRAM-like data-bus handshake. It formats store data and load results and detects address-error exceptions. It stalls the pipeline until the bus transaction completes, and holds the load result while the rest of the pipe is frozen.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- l_s_typeM  in  8  one-hot access type: [0]LB [1]LBU [2]LH [3]LHU [4]LW [5]SB [6]SH [7]SW; 0 = no access
- alu_outM  in  32  effective address
- rt_valueM  in  32  raw store data
- exc_flushM  in  1  exception being taken for the M-stage instruction; suppresses a new request
- stall_ext  in  1  stall of the M stage from any source other than this block
- data_req  out  1  bus request
- data_wr  out  1  1 = write, 0 = read
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  equals alu_outM
- data_wdata  out  32  replicated store data
- data_addr_ok  in  1  request accepted this cycle
- data_data_ok  in  1  read data valid or write complete this cycle
- data_rdata  in  32  raw read word
- adelM  out  1  load address error
- adesM  out  1  store address error
- badvaddrM  out  32  equals alu_outM
- mem_rdataM  out  32  extended load result
- mem_stall  out  1  M stage must stall for this block

## Operation
- Address error, all combinational:
  - halfword access with addr[0]=1 is an error; word access with addr[1:0]≠0 is an error.
  - Loads raise adelM, stores raise adesM.
  - An error suppresses the request.
- `go` = l_s_typeM≠0 & ~adelM & ~adesM & ~exc_flushM.
- Store data:
  - SB: {4{rt[7:0]}}
  - SH: {2{rt[15:0]}}
  - SW: rt
  - Byte selection is the responsibility of the slave via data_addr and data_size.
- Load extension:
  - Select the byte or half of data_rdata by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- FSM states: IDLE, WAIT_ADDR, WAIT_DATA, DONE.
  - IDLE:
    - data_req = go.
    - go & addr_ok → WAIT_DATA.
    - go & ~addr_ok → WAIT_ADDR.
  - WAIT_ADDR:
    - data_req = 1; the request is held with stable fields, because inputs are frozen by mem_stall.
    - addr_ok → WAIT_DATA.
  - WAIT_DATA:
    - data_req = 0.
    - On data_ok: latch the extended result into result_r. If stall_ext → DONE, else → IDLE.
  - DONE:
    - mem_rdataM = result_r.
    - ~stall_ext → IDLE.
- mem_stall = (go & IDLE & ~(data_ok in same cycle, impossible, so) 1) | WAIT_ADDR | (WAIT_DATA & ~data_ok). In DONE, mem_stall = 0.
- mem_rdataM = extended data_rdata in the data_ok cycle, result_r in DONE, else result_r.
- Once accepted, a transaction is never cancelled.
  - exc_flushM in WAIT_DATA: wait for data_ok, discard the data (result_r not updated), → IDLE.
  - exc_flushM in WAIT_ADDR: drop data_req next cycle, → IDLE. This is legal because addr_ok was not seen.

## Timing
- Reset: state IDLE, result_r=0, data_req=0, mem_stall=0, mem_rdataM=0.
- Minimum load latency: request cycle N with addr_ok, data_ok in N+1. mem_stall is high in N and low in N+1; the result is valid in N+1.
- addr_ok and data_ok are never both asserted for the same transaction in the same cycle.
- data_ok seen in IDLE or DONE is ignored.
- Back-to-back accesses: a new instruction arriving in M in the cycle after leaving WAIT_DATA/DONE issues its request that cycle, with no bubble.
- rst mid-transaction returns to IDLE immediately. An outstanding bus response is the bus owner's concern; it is reset simultaneously.

## Test plan
- LB at 0x1003, data_rdata=0x80FF7F01, addr_ok cycle 0, data_ok cycle 1 → mem_rdataM=0xFFFFFF80, mem_stall high exactly 1 cycle.
- SH rt=0x1234ABCD at 0x2002 → data_req=1, data_wr=1, data_size=1, data_wdata=0xABCDABCD; addr_ok delayed 3 cycles → req held 4 cycles with stable fields.
- LW at 0x0006 → adelM=1, badvaddrM=0x6, data_req never asserted, mem_stall=0.
- LHU at 0x0002, data_rdata=0xBEEF0000, stall_ext high 2 cycles after data_ok → mem_rdataM=0x0000BEEF held through DONE, returns IDLE when stall_ext falls.
- LW accepted, exc_flushM asserted in WAIT_DATA, data_ok 2 cycles later → result_r unchanged, FSM IDLE, no second request.
- rst during WAIT_ADDR → next cycle data_req=0, mem_stall=0, mem_rdataM=0.
